// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: scan FSM states,
// the 4x4 key-code lookup and the column-drive helper.
package keypad_pkg;

  typedef enum logic {
    SCAN,
    HOLD
  } scan_state_t;

  localparam logic [3:0] KEY_NONE = 4'h0;

  // Row-major key codes: index {row, col}; row3 is the * 0 # D row.
  localparam logic [0:15][3:0] KEY_LUT = 64'h123A_456B_789C_E0FD;

  function automatic logic [3:0] key_of(input logic [1:0] row, input logic [1:0] col);
    return KEY_LUT[{row, col}];
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the active-low row lines; resets to all-high
// so an idle keypad is seen while the chain refills.
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with single-key detection and hold tracking.
// Define KEYPAD_SCANNER_SYNC_EN to insert a two-flop row synchronizer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int unsigned CW = 20;

  logic [3:0]    rows_s;
  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [1:0]    row_lat;
  logic          tc;
  logic [3:0]    low;
  logic          single;
  logic [1:0]    row_idx;

`ifdef KEYPAD_SCANNER_SYNC_EN
  row_sync #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows_n),
    .q     (rows_s)
  );
`else
  assign rows_s = rows_n;
`endif

  always_comb begin
    tc      = (cnt == CW'(SETTLE_CYCLES - 1));
    low     = ~rows_s;
    single  = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
    row_idx = 2'd0;
    case (low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      cnt         <= '0;
      col_idx     <= 2'd0;
      row_lat     <= 2'd0;
      cols_n      <= 4'b1110;
      key_code    <= KEY_NONE;
      key_pressed <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) begin
        case (state)
          SCAN: begin
            if (single) begin
              state       <= HOLD;
              row_lat     <= row_idx;
              key_code    <= key_of(row_idx, col_idx);
              key_pressed <= 1'b1;
            end else begin
              col_idx <= col_idx + 2'd1;
              cols_n  <= col_drive(col_idx + 2'd1);
            end
          end
          HOLD: begin
            // Only the latched row decides release; other rows are don't-care.
            if (rows_s[row_lat]) begin
              state       <= SCAN;
              key_pressed <= 1'b0;
              col_idx     <= col_idx + 2'd1;
              cols_n      <= col_drive(col_idx + 2'd1);
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SETTLE_CYCLES=4); expectations adapt
// to KEYPAD_SCANNER_SYNC_EN where the synchronizer shifts detection timing.
module tb_keypad_scanner;

`ifdef KEYPAD_SCANNER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [3:0] key_code;
  logic       key_pressed;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows_n      (rows_n),
    .cols_n      (cols_n),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    rows_n = 4'b1111;
    tick(3);
    chk("rst_cols", cols_n, 4'b1110);
    chk("rst_kp", {3'b0, key_pressed}, 4'd0);
    chk("rst_code", key_code, 4'h0);

    // Idle rotation; edge numbers below count from reset release.
    reset = 1'b0;
    tick(3);                                   // e3
    chk("idle_e3_cols", cols_n, 4'b1110);
    tick(1);                                   // e4
    chk("idle_e4_cols", cols_n, 4'b1101);
    tick(4);                                   // e8
    chk("idle_e8_cols", cols_n, 4'b1011);
    tick(4);                                   // e12
    chk("idle_e12_cols", cols_n, 4'b0111);
    tick(4);                                   // e16
    chk("idle_e16_cols", cols_n, 4'b1110);
    chk("idle_kp", {3'b0, key_pressed}, 4'd0);

    // Two rows low: no detection, column advances.
    rows_n = 4'b1100;
    tick(4);                                   // e20
    chk("multi_cols", cols_n, 4'b1101);
    chk("multi_kp", {3'b0, key_pressed}, 4'd0);
    rows_n = 4'b1111;

    // Key 6 (row1, col2) pressed for the col2 window onward.
    tick(4);                                   // e24
    chk("k6_pre_cols", cols_n, 4'b1011);
    rows_n = 4'b1101;
    tick(3);                                   // e27
    chk("k6_e27_kp", {3'b0, key_pressed}, 4'd0);
    tick(1);                                   // e28
    chk("k6_kp", {3'b0, key_pressed}, 4'd1);
    chk("k6_code", key_code, 4'h6);
    rows_n = 4'b1100;                          // extra row must be ignored
    tick(4);                                   // e32
    chk("k6_hold_kp", {3'b0, key_pressed}, 4'd1);
    chk("k6_hold_cols", cols_n, 4'b1011);
    rows_n = 4'b1111;
    tick(3);                                   // e35
    chk("k6_midwin_kp", {3'b0, key_pressed}, 4'd1);
    tick(1);                                   // e36
    chk("k6_rel_kp", {3'b0, key_pressed}, 4'd0);
    chk("k6_rel_cols", cols_n, 4'b0111);
    chk("k6_rel_code", key_code, 4'h6);

    // Key 0 (row3, col1) held, then reset mid-hold.
    tick(8);                                   // e44
    chk("k0_pre_cols", cols_n, 4'b1101);
    rows_n = 4'b0111;
    tick(4);                                   // e48
    chk("k0_kp", {3'b0, key_pressed}, 4'd1);
    chk("k0_code", key_code, 4'h0);
    tick(2);                                   // e50
    reset = 1'b1;
    tick(1);                                   // e51
    chk("k0_rst_kp", {3'b0, key_pressed}, 4'd0);
    chk("k0_rst_cols", cols_n, 4'b1110);
    reset  = 1'b0;
    rows_n = 4'b1111;
    tick(4);                                   // f4
    chk("k0_re_pre_cols", cols_n, 4'b1101);
    chk("k0_re_pre_kp", {3'b0, key_pressed}, 4'd0);
    rows_n = 4'b0111;
    tick(4);                                   // f8
    chk("k0_re_kp", {3'b0, key_pressed}, 4'd1);
    chk("k0_re_code", key_code, 4'h0);
    chk("k0_re_cols", cols_n, 4'b1101);
    rows_n = 4'b1111;
    tick(4);                                   // f12
    chk("k0_rel_cols", cols_n, 4'b1011);

    // Row0 pressed one cycle before the col2 terminal count.
    tick(3);                                   // f15
    rows_n = 4'b1110;
    tick(1);                                   // f16
    chk("late_f16_kp", {3'b0, key_pressed}, SYNC ? 4'd0 : 4'd1);
    tick(4);                                   // f20
    chk("late_f20_kp", {3'b0, key_pressed}, 4'd1);
    chk("late_code", key_code, SYNC ? 4'hA : 4'h3);
    chk("late_cols", cols_n, SYNC ? 4'b0111 : 4'b1011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
